// File: rtl/eth_frame_gen_pkg.sv
// Shared constants, FSM encoding and length clamp for the Ethernet test-frame generator.
package eth_frame_gen_pkg;

    localparam int unsigned HDR_LEN     = 14;
    localparam int unsigned SEQ_OFF     = 14;
    localparam int unsigned PAYLOAD_OFF = 18;
    localparam int unsigned MIN_LEN     = 60;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } state_e;

    function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                              input logic [10:0] max_len);
        if (len < 11'(MIN_LEN)) begin
            return 11'(MIN_LEN);
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/eth_frame_gen_byte_sel.sv
// Combinational byte mux: header fields, big-endian sequence number, then (i-18) mod 256.
module eth_frame_gen_byte_sel
    import eth_frame_gen_pkg::*;
(
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic [31:0] seq,
    input  logic [10:0] idx,
    output logic [7:0]  data
);

    logic [111:0] hdr;
    logic [111:0] hdr_sh;
    logic [31:0]  seq_sh;
    logic [7:0]   pay;

    always_comb begin
        hdr    = {dst_mac, src_mac, ethertype};
        hdr_sh = hdr << {idx[3:0], 3'b000};
        // Sequence bytes sit at 14..17, so (idx - 14) mod 4 picks the byte.
        seq_sh = seq << {idx[1:0] - 2'(SEQ_OFF), 3'b000};
        pay    = idx[7:0] - 8'(PAYLOAD_OFF);

        if (idx < 11'(HDR_LEN)) begin
            data = hdr_sh[111:104];
        end else if (idx < 11'(PAYLOAD_OFF)) begin
            data = seq_sh[31:24];
        end else begin
            data = pay;
        end
    end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet test-traffic source for the MAC transmit AXI-Stream port, with frame/byte/error
// counters. Stream outputs are registered from next-state values so byte 0 leaves with SEND.
module eth_frame_gen
    import eth_frame_gen_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1514
) (
    input  logic        gtx_clk,
    input  logic        gtx_rst,
    input  logic        enable,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic [10:0] frame_len,
    input  logic [15:0] gap_cycles,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    input  logic        tx_axis_tready,
    input  logic        tx_error,
    output logic        busy,
    output logic [31:0] frame_count,
    output logic [31:0] byte_count,
    output logic [15:0] error_count
);

    state_e      state_q, state_d;
    logic [10:0] idx_q, idx_d;
    logic [10:0] len_q, len_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] eth_q, eth_d;
    logic [31:0] seq_q, seq_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        busy_q, busy_d;
    logic [31:0] frame_count_q, frame_count_d;
    logic [31:0] byte_count_q, byte_count_d;
    logic [15:0] error_count_q, error_count_d;
    logic [7:0]  sel_byte;
    logic        hs;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        dst_d         = dst_q;
        src_d         = src_q;
        eth_d         = eth_q;
        seq_d         = seq_q;
        gap_d         = gap_q;
        frame_count_d = frame_count_q;
        byte_count_d  = byte_count_q;
        error_count_d = error_count_q;
        hs            = tvalid_q & tx_axis_tready;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StSend;
                    dst_d   = dst_mac;
                    src_d   = src_mac;
                    eth_d   = ethertype;
                    seq_d   = frame_count_q;
                    len_d   = clamp_len(frame_len, 11'(MAX_LEN));
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (hs) begin
                    byte_count_d = byte_count_q + 32'd1;
                    if (tlast_q) begin
                        frame_count_d = frame_count_q + 32'd1;
                        gap_d         = gap_cycles;
                        state_d       = (gap_cycles == 16'd0) ? StIdle : StGap;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q - 16'd1;
                if (gap_q <= 16'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (tx_error && (error_count_q != 16'hFFFF)) begin
            error_count_d = error_count_q + 16'd1;
        end
    end

    eth_frame_gen_byte_sel u_byte_sel (
        .dst_mac   (dst_d),
        .src_mac   (src_d),
        .ethertype (eth_d),
        .seq       (seq_d),
        .idx       (idx_d),
        .data      (sel_byte)
    );

    always_comb begin
        tvalid_d = (state_d == StSend);
        tlast_d  = tvalid_d && (idx_d == len_d - 11'd1);
        tdata_d  = tvalid_d ? sel_byte : 8'h00;
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge gtx_clk or posedge gtx_rst) begin
        if (gtx_rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            len_q         <= '0;
            dst_q         <= '0;
            src_q         <= '0;
            eth_q         <= '0;
            seq_q         <= '0;
            gap_q         <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            byte_count_q  <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            dst_q         <= dst_d;
            src_q         <= src_d;
            eth_q         <= eth_d;
            seq_q         <= seq_d;
            gap_q         <= gap_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
            byte_count_q  <= byte_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign tx_axis_tdata  = tdata_q;
    assign tx_axis_tvalid = tvalid_q;
    assign tx_axis_tlast  = tlast_q;
    assign tx_axis_tuser  = 1'b0;
    assign busy           = busy_q;
    assign frame_count    = frame_count_q;
    assign byte_count     = byte_count_q;
    assign error_count    = error_count_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Scoreboard bench for eth_frame_gen: stimulus queues expected bytes, a negedge monitor checks
// every handshake, stall stability, in-frame bubbles and inter-frame idle lengths.
module tb_eth_frame_gen;

    logic        gtx_clk = 1'b0;
    logic        gtx_rst;
    logic        enable;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [10:0] frame_len;
    logic [15:0] gap_cycles;
    logic [7:0]  tx_axis_tdata;
    logic        tx_axis_tvalid;
    logic        tx_axis_tlast;
    logic        tx_axis_tuser;
    logic        tx_axis_tready = 1'b1;
    logic        tx_error;
    logic        busy;
    logic [31:0] frame_count;
    logic [31:0] byte_count;
    logic [15:0] error_count;

    int          errors = 0;
    int          checks = 0;
    logic [8:0]  exp_q[$];
    int          gaps_q[$];
    int          mon_idx = 0;
    bit          stall_mode = 1'b0;

    always #4 gtx_clk = ~gtx_clk;

    eth_frame_gen #(.MAX_LEN(1514)) dut (
        .gtx_clk        (gtx_clk),
        .gtx_rst        (gtx_rst),
        .enable         (enable),
        .dst_mac        (dst_mac),
        .src_mac        (src_mac),
        .ethertype      (ethertype),
        .frame_len      (frame_len),
        .gap_cycles     (gap_cycles),
        .tx_axis_tdata  (tx_axis_tdata),
        .tx_axis_tvalid (tx_axis_tvalid),
        .tx_axis_tlast  (tx_axis_tlast),
        .tx_axis_tuser  (tx_axis_tuser),
        .tx_axis_tready (tx_axis_tready),
        .tx_error       (tx_error),
        .busy           (busy),
        .frame_count    (frame_count),
        .byte_count     (byte_count),
        .error_count    (error_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge gtx_clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                              input logic [31:0] seq, input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            if (i < 6)       b = d[47-8*i -: 8];
            else if (i < 12) b = s[47-8*(i-6) -: 8];
            else if (i < 14) b = et[15-8*(i-12) -: 8];
            else if (i < 18) b = seq[31-8*(i-14) -: 8];
            else             b = 8'((i - 18) % 256);
            exp_q.push_back({(i == len - 1), b});
        end
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int c = 0;
        while (frame_count != 32'(target) && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, frame_count, 32'(target));
    endtask

    task automatic wait_idx(input int target, input int budget);
        int c = 0;
        while (mon_idx != target && c < budget) begin
            tick(1);
            c++;
        end
        chk("wait_byte_index", 32'(mon_idx), 32'(target));
    endtask

    always @(posedge gtx_clk) begin
        #1;
        tx_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: sampled mid-cycle, so tready/tvalid describe the coming edge's handshake.
    bit         in_frame = 1'b0;
    bit         prev_stall = 1'b0;
    bit         seen_frame = 1'b0;
    logic [8:0] stall_val = '0;
    int         low_run = 0;

    always @(negedge gtx_clk) begin
        if (gtx_rst) begin
            in_frame   = 1'b0;
            prev_stall = 1'b0;
            seen_frame = 1'b0;
            low_run    = 0;
            mon_idx    = 0;
        end else begin
            if (in_frame) chk("no_bubble_tvalid", 32'(tx_axis_tvalid), 32'd1);
            if (prev_stall) chk("stall_hold", {23'd0, tx_axis_tlast, tx_axis_tdata},
                                {23'd0, stall_val});
            if (tx_axis_tvalid) begin
                if (!in_frame && seen_frame) gaps_q.push_back(low_run);
                low_run = 0;
                if (tx_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected none", tx_axis_tdata);
                    end else begin
                        chk("stream_byte", {23'd0, tx_axis_tlast, tx_axis_tdata},
                            {23'd0, exp_q.pop_front()});
                    end
                    chk("tuser", 32'(tx_axis_tuser), 32'd0);
                    prev_stall = 1'b0;
                    if (tx_axis_tlast) begin
                        in_frame   = 1'b0;
                        seen_frame = 1'b1;
                        mon_idx    = 0;
                    end else begin
                        in_frame = 1'b1;
                        mon_idx++;
                    end
                end else begin
                    prev_stall = 1'b1;
                    stall_val  = {tx_axis_tlast, tx_axis_tdata};
                    in_frame   = 1'b1;
                end
            end else begin
                low_run++;
            end
        end
    end

    logic [7:0] hdr1 [18];

    initial begin
        gtx_rst    = 1'b1;
        enable     = 1'b0;
        dst_mac    = '0;
        src_mac    = '0;
        ethertype  = '0;
        frame_len  = 11'd60;
        gap_cycles = 16'd0;
        tx_error   = 1'b0;
        hdr1 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                 8'h88, 8'hB5, 8'h00, 8'h00, 8'h00, 8'h00};

        tick(3);
        chk("rst_tvalid", 32'(tx_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(tx_axis_tdata), 32'd0);
        chk("rst_tlast", 32'(tx_axis_tlast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_byte_count", byte_count, 32'd0);
        chk("rst_error_count", 32'(error_count), 32'd0);
        gtx_rst = 1'b0;
        tick(2);

        // Basic 60-byte broadcast frame against a literal header.
        dst_mac   = 48'hFFFF_FFFF_FFFF;
        src_mac   = 48'h0200_0000_0001;
        ethertype = 16'h88B5;
        for (int i = 0; i < 60; i++)
            exp_q.push_back({(i == 59), (i < 18) ? hdr1[i] : 8'(i - 18)});
        pulse_enable();
        chk("first_tvalid", 32'(tx_axis_tvalid), 32'd1);
        chk("first_tdata", 32'(tx_axis_tdata), 32'hFF);
        chk("first_busy", 32'(busy), 32'd1);
        wait_frames(1, 200, "f1_frame_count");
        tick(3);
        chk("f1_byte_count", byte_count, 32'd60);
        chk("f1_busy_after", 32'(busy), 32'd0);

        // Length clamping: 20 -> 60, 2000 -> 1514 (payload wraps FF->00).
        dst_mac   = 48'h0011_2233_4455;
        src_mac   = 48'h0200_0000_00AA;
        ethertype = 16'h0800;
        frame_len = 11'd20;
        push_frame(dst_mac, src_mac, ethertype, 32'd1, 60);
        pulse_enable();
        wait_frames(2, 200, "f2_frame_count");
        frame_len = 11'd2000;
        push_frame(dst_mac, src_mac, ethertype, 32'd2, 1514);
        pulse_enable();
        wait_frames(3, 2000, "f3_frame_count");
        tick(2);
        chk("f3_byte_count", byte_count, 32'd1634);

        // Random back-pressure plus three tx_error cycles overlapping byte counting.
        frame_len  = 11'd100;
        stall_mode = 1'b1;
        push_frame(dst_mac, src_mac, ethertype, 32'd3, 100);
        pulse_enable();
        tx_error = 1'b1;
        tick(3);
        tx_error = 1'b0;
        wait_frames(4, 1000, "f4_frame_count");
        stall_mode = 1'b0;
        tick(3);
        chk("f4_byte_count", byte_count, 32'd1734);
        chk("error_count_3", 32'(error_count), 32'd3);

        // Reset mid-frame.
        frame_len = 11'd200;
        push_frame(dst_mac, src_mac, ethertype, 32'd4, 200);
        pulse_enable();
        wait_idx(50, 300);
        gtx_rst = 1'b1;
        #1;
        chk("midrst_tvalid", 32'(tx_axis_tvalid), 32'd0);
        chk("midrst_frame_count", frame_count, 32'd0);
        chk("midrst_byte_count", byte_count, 32'd0);
        chk("midrst_error_count", 32'(error_count), 32'd0);
        exp_q.delete();
        tick(2);

        // Held enable: gap 0 then 5, then drop enable at byte 30 of the third frame.
        frame_len = 11'd60;
        gap_cycles = 16'd0;
        gaps_q.delete();
        for (int f = 0; f < 3; f++) push_frame(dst_mac, src_mac, ethertype, 32'(f), 60);
        gtx_rst = 1'b0;
        enable  = 1'b1;
        wait_frames(1, 200, "h1_frame_count");
        gap_cycles = 16'd5;
        wait_frames(2, 200, "h2_frame_count");
        wait_idx(30, 200);
        enable = 1'b0;
        wait_frames(3, 200, "h3_frame_count");
        tick(40);
        chk("held_frame_count_final", frame_count, 32'd3);
        chk("held_tvalid_idle", 32'(tx_axis_tvalid), 32'd0);
        chk("held_busy_idle", 32'(busy), 32'd0);
        chk("held_exp_drained", 32'(exp_q.size()), 32'd0);
        chk("held_gap_count", 32'(gaps_q.size()), 32'd2);
        if (gaps_q.size() >= 2) begin
            chk("gap0_low_cycles", 32'(gaps_q[0]), 32'd1);
            chk("gap5_low_cycles", 32'(gaps_q[1]), 32'd6);
        end

        // Error counter saturation.
        tx_error = 1'b1;
        tick(65534);
        chk("error_count_65534", 32'(error_count), 32'd65534);
        tick(10);
        tx_error = 1'b0;
        tick(2);
        chk("error_count_sat", 32'(error_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
